// File: rtl/reaction_pkg.sv
// Shared types for the reaction-time stopwatch and its automated responder:
// stimulus colour decode and the responder state encoding.
package reaction_pkg;

    localparam int MS_PER_S = 1000;
    localparam int CNT_W    = 16;

    typedef enum logic [2:0] {
        GREEN   = 3'd0,
        DARK    = 3'd1,
        WHITE   = 3'd2,
        RED     = 3'd3,
        YELLOW  = 3'd4,
        INVALID = 3'd5
    } colour_t;

    typedef enum logic [2:0] {
        ST_OFF          = 3'd0,
        ST_PRESS_START  = 3'd1,
        ST_WAIT_READY   = 3'd2,
        ST_DELAY        = 3'd3,
        ST_PRESS_ENTER  = 3'd4,
        ST_SHOW         = 3'd5,
        ST_PRESS_RESULT = 3'd6,
        ST_RECOVER      = 3'd7
    } state_t;

    // Bit order is {r, g, b}; unlisted combinations decode to INVALID.
    function automatic colour_t decode_colour(input logic [2:0] rgb);
        case (rgb)
            3'b010:  return GREEN;
            3'b000:  return DARK;
            3'b111:  return WHITE;
            3'b100:  return RED;
            3'b110:  return YELLOW;
            default: return INVALID;
        endcase
    endfunction

endpackage

// File: rtl/reaction_responder_ms_tick.sv
// Free-running millisecond strobe: a one-cycle pulse every CLK_HZ/1000 clocks.
module ms_tick
    import reaction_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = (CLK_HZ / MS_PER_S) > 0 ? (CLK_HZ / MS_PER_S) : 1;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] prescale;

    always_ff @(posedge clk) begin
        if (rst) begin
            prescale <= '0;
            tick     <= 1'b0;
        end else if (prescale == LAST) begin
            prescale <= '0;
            tick     <= 1'b1;
        end else begin
            prescale <= prescale + 1'b1;
            tick     <= 1'b0;
        end
    end

endmodule

// File: rtl/reaction_responder.sv
// Automated stopwatch player: watches the stimulus colour and presses
// start/enter so the measured reaction time equals delay_ms.
module reaction_responder
    import reaction_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int START_HOLD = 20,
    parameter int DISPLAY_MS = 1000,
    parameter int ENTER_MAX  = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [9:0] delay_ms,
    input  logic       r_in,
    input  logic       g_in,
    input  logic       b_in,
    output logic       start_out,
    output logic       enter_out,
    output logic       busy,
    output logic [7:0] rounds,
    output logic       early_flag,
    output logic       late_flag
);

    localparam logic [CNT_W-1:0] HOLD_CNT  = CNT_W'(START_HOLD);
    localparam logic [CNT_W-1:0] SHOW_CNT  = CNT_W'(DISPLAY_MS);
    localparam logic [CNT_W-1:0] ENTER_CNT = CNT_W'(ENTER_MAX);

    logic             tick;
    colour_t          colour_p1;
    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic [9:0]       delay_p1;
    logic             early_set;
    logic             late_set;
    logic             round_done;

    ms_tick #(.CLK_HZ(CLK_HZ)) u_ms_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Stage p1: registered colour decode
    always_ff @(posedge clk) begin
        if (rst) begin
            colour_p1 <= DARK;
        end else begin
            colour_p1 <= decode_colour({r_in, g_in, b_in});
        end
    end

    // Colour checks come before count checks so a colour change beats a tick.
    always_comb begin
        next_state = state;
        case (state)
            ST_OFF: begin
                if (enable && colour_p1 == GREEN) next_state = ST_PRESS_START;
            end
            ST_PRESS_START: begin
                if (count == HOLD_CNT) next_state = ST_WAIT_READY;
            end
            ST_WAIT_READY: begin
                if (colour_p1 == WHITE)                          next_state = ST_DELAY;
                else if (colour_p1 == RED || colour_p1 == YELLOW) next_state = ST_RECOVER;
                else if (!enable)                                next_state = ST_OFF;
            end
            ST_DELAY: begin
                if (colour_p1 == YELLOW)               next_state = ST_RECOVER;
                else if (count == CNT_W'(delay_p1))    next_state = ST_PRESS_ENTER;
            end
            ST_PRESS_ENTER: begin
                if (colour_p1 != WHITE)      next_state = ST_SHOW;
                else if (count == ENTER_CNT) next_state = ST_RECOVER;
            end
            ST_SHOW: begin
                if (count == SHOW_CNT) next_state = ST_PRESS_RESULT;
            end
            ST_PRESS_RESULT: begin
                if (count == HOLD_CNT) next_state = ST_RECOVER;
            end
            ST_RECOVER: begin
                if (colour_p1 == GREEN) next_state = enable ? ST_PRESS_START : ST_OFF;
            end
            default: next_state = ST_OFF;
        endcase
    end

    assign early_set  = (state == ST_WAIT_READY) && (colour_p1 == RED);
    assign late_set   = ((state == ST_WAIT_READY) || (state == ST_DELAY)) && (colour_p1 == YELLOW);
    assign round_done = (state == ST_PRESS_ENTER) && (colour_p1 != WHITE);

    // Stage p2: state, ms counter and Moore outputs decoded from next_state
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_OFF;
            count      <= '0;
            start_out  <= 1'b0;
            enter_out  <= 1'b0;
            busy       <= 1'b0;
            rounds     <= 8'd0;
            early_flag <= 1'b0;
            late_flag  <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                count <= '0;
            end else if (tick) begin
                count <= count + 1'b1;
            end
            start_out <= (next_state == ST_PRESS_START) || (next_state == ST_PRESS_RESULT);
            enter_out <= (next_state == ST_PRESS_ENTER);
            busy      <= (next_state != ST_OFF);
            if (round_done) rounds <= rounds + 8'd1;
            if (early_set)  early_flag <= 1'b1;
            if (late_set)   late_flag  <= 1'b1;
        end
    end

    // Latency is frozen on DELAY entry so a mid-round change cannot skew it.
    always_ff @(posedge clk) begin
        if (state != ST_DELAY && next_state == ST_DELAY) begin
            delay_p1 <= delay_ms;
        end
    end

endmodule

// File: tb/tb_reaction_responder.sv
// Scenario bench for reaction_responder with one ms tick per clock.
module tb_reaction_responder;

    localparam int CLK_HZ     = 1000;
    localparam int START_HOLD = 2;
    localparam int DISPLAY_MS = 5;
    localparam int ENTER_MAX  = 50;

    localparam logic [2:0] C_GREEN = 3'b010;
    localparam logic [2:0] C_DARK  = 3'b000;
    localparam logic [2:0] C_WHITE = 3'b111;
    localparam logic [2:0] C_RED   = 3'b100;
    localparam logic [2:0] C_YEL   = 3'b110;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [9:0] delay_ms;
    logic       r_in, g_in, b_in;
    logic       start_out, enter_out, busy, early_flag, late_flag;
    logic [7:0] rounds;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         overlap = 0;
    logic [7:0] model_rounds;

    typedef struct {
        int         rise;
        logic [7:0] rounds;
    } exp_t;
    exp_t sb[$];

    reaction_responder #(
        .CLK_HZ     (CLK_HZ),
        .START_HOLD (START_HOLD),
        .DISPLAY_MS (DISPLAY_MS),
        .ENTER_MAX  (ENTER_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .delay_ms   (delay_ms),
        .r_in       (r_in),
        .g_in       (g_in),
        .b_in       (b_in),
        .start_out  (start_out),
        .enter_out  (enter_out),
        .busy       (busy),
        .rounds     (rounds),
        .early_flag (early_flag),
        .late_flag  (late_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (start_out === 1'b1 && enter_out === 1'b1) begin
            overlap++;
            $display("FAIL overlap at cycle %0d: start_out=1 enter_out=1, required never both high", cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic set_col(input logic [2:0] rgb);
        {r_in, g_in, b_in} = rgb;
    endtask

    function automatic logic pick(input int which);
        case (which)
            0:       return start_out;
            1:       return enter_out;
            default: return busy;
        endcase
    endfunction

    task automatic wait_sig(input int which, input logic level, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pick(which) === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // GREEN -> start press; hold is START_HOLD+1 clocks (count runs 0..START_HOLD).
    // Leaves the responder in WAIT_READY with the colour DARK.
    task automatic press_start_phase(input string tag);
        bit ok;
        int len;
        set_col(C_GREEN);
        wait_sig(0, 1'b1, 6, ok);
        set_col(C_DARK);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s start_rise: start_out=%b, required 1 within 6 cycles", tag, start_out);
        end
        len = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (start_out !== 1'b1) break;
            len++;
        end
        n_cmp++;
        if (len !== START_HOLD + 1) begin
            n_bad++;
            $display("FAIL %s start_hold: held %0d cycles, required %0d", tag, len, START_HOLD + 1);
        end
    endtask

    // A full successful round ending in RECOVER. WHITE is registered on one
    // edge, DELAY is entered on the next and lasts d+1 clocks.
    task automatic do_round(input string tag, input int d, input int hold);
        bit   ok;
        int   c0, c1, cf, len;
        exp_t e;
        press_start_phase(tag);
        delay_ms = 10'(d);
        c0 = cyc;
        set_col(C_WHITE);
        sb.push_back('{rise: c0 + d + 3, rounds: model_rounds + 8'd1});
        model_rounds = model_rounds + 8'd1;
        wait_sig(1, 1'b1, d + 10, ok);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{rise: -1, rounds: 8'd0};
        n_cmp++;
        if (!ok || cyc !== e.rise) begin
            n_bad++;
            $display("FAIL %s enter_rise: rose at cycle %0d (seen=%0b), required %0d", tag, cyc, ok, e.rise);
        end
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            n_cmp++;
            if (enter_out !== 1'b1) begin
                n_bad++;
                $display("FAIL %s enter_hold: enter_out=%b, required 1 while WHITE", tag, enter_out);
            end
        end
        c1 = cyc;
        set_col(C_DARK);
        wait_sig(1, 1'b0, 5, ok);
        n_cmp++;
        if (!ok || cyc !== c1 + 2) begin
            n_bad++;
            $display("FAIL %s enter_fall: fell at cycle %0d, required %0d", tag, cyc, c1 + 2);
        end
        n_cmp++;
        if (rounds !== e.rounds) begin
            n_bad++;
            $display("FAIL %s rounds: rounds=%0d, required %0d", tag, rounds, e.rounds);
        end
        cf = cyc;
        wait_sig(0, 1'b1, DISPLAY_MS + 10, ok);
        n_cmp++;
        if (!ok || cyc !== cf + DISPLAY_MS + 1) begin
            n_bad++;
            $display("FAIL %s result_press: start rose at %0d, required %0d", tag, cyc, cf + DISPLAY_MS + 1);
        end
        len = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (start_out !== 1'b1) break;
            len++;
        end
        n_cmp++;
        if (len !== START_HOLD + 1) begin
            n_bad++;
            $display("FAIL %s result_hold: held %0d cycles, required %0d", tag, len, START_HOLD + 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        delay_ms = 10'd0;
        set_col(C_DARK);
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({start_out, enter_out, busy, rounds, early_flag, late_flag} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: start=%b enter=%b busy=%b rounds=%0d early=%b late=%b, required all 0",
                     start_out, enter_out, busy, rounds, early_flag, late_flag);
        end
        rst = 1'b0;
        model_rounds = 8'd0;
        set_col(C_GREEN);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || start_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_disabled: busy=%b start=%b, required 0 0", busy, start_out);
        end
        set_col(C_DARK);
        @(negedge clk);
    endtask

    task automatic test_round();
        enable = 1'b1;
        do_round("round37", 37, 3);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL round_recover_busy: busy=%b, required 1", busy);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        press_start_phase("rstmid");
        delay_ms = 10'd3;
        set_col(C_WHITE);
        wait_sig(1, 1'b1, 15, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL rstmid_enter: enter_out=%b, required 1", enter_out);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({start_out, enter_out, busy, rounds, early_flag, late_flag} !== 13'd0) begin
            n_bad++;
            $display("FAIL rstmid_outputs: start=%b enter=%b busy=%b rounds=%0d, required all 0",
                     start_out, enter_out, busy, rounds);
        end
        rst = 1'b0;
        set_col(C_DARK);
        model_rounds = 8'd0;
        sb.delete();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_off: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_early();
        press_start_phase("early");
        set_col(C_RED);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (early_flag !== 1'b1 || late_flag !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL early_flag: early=%b late=%b busy=%b, required 1 0 1", early_flag, late_flag, busy);
        end
        set_col(C_DARK);
        repeat (6) @(negedge clk);
        n_cmp++;
        if (enter_out !== 1'b0 || start_out !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL early_wait_green: enter=%b start=%b busy=%b, required 0 0 1", enter_out, start_out, busy);
        end
        press_start_phase("early_regreen");
    endtask

    task automatic test_late();
        delay_ms = 10'd500;
        set_col(C_WHITE);
        repeat (4) @(negedge clk);
        delay_ms = 10'd0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (enter_out !== 1'b0) begin
            n_bad++;
            $display("FAIL late_delay_resample: enter_out=%b, required 0", enter_out);
        end
        set_col(C_YEL);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (late_flag !== 1'b1 || early_flag !== 1'b1) begin
            n_bad++;
            $display("FAIL late_flag: late=%b early=%b, required 1 1", late_flag, early_flag);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (enter_out !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL late_no_enter: enter=%b busy=%b, required 0 1", enter_out, busy);
        end
        set_col(C_DARK);
        @(negedge clk);
    endtask

    task automatic test_enter_cap();
        bit   ok;
        int   c0, len;
        exp_t e;
        press_start_phase("cap");
        delay_ms = 10'd0;
        c0 = cyc;
        set_col(C_WHITE);
        sb.push_back('{rise: c0 + 3, rounds: model_rounds});
        wait_sig(1, 1'b1, 10, ok);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{rise: -1, rounds: 8'd0};
        n_cmp++;
        if (!ok || cyc !== e.rise) begin
            n_bad++;
            $display("FAIL cap_rise_d0: rose at %0d, required %0d", cyc, e.rise);
        end
        // count runs 0..ENTER_MAX inclusive at one tick per clock
        len = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (enter_out !== 1'b1) break;
            len++;
        end
        n_cmp++;
        if (len !== ENTER_MAX + 1) begin
            n_bad++;
            $display("FAIL cap_hold: enter high %0d cycles, required %0d", len, ENTER_MAX + 1);
        end
        n_cmp++;
        if (rounds !== e.rounds || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL cap_rounds: rounds=%0d busy=%b, required %0d 1", rounds, busy, e.rounds);
        end
        set_col(C_DARK);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        set_col(C_GREEN);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || start_out !== 1'b0) begin
            n_bad++;
            $display("FAIL cap_disable_off: busy=%b start=%b, required 0 0", busy, start_out);
        end
        set_col(C_DARK);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_rounds = 8'd0;
        sb.delete();
        @(negedge clk);
        n_cmp++;
        if (early_flag !== 1'b0 || late_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_flags_clear: early=%b late=%b, required 0 0", early_flag, late_flag);
        end
        enable = 1'b1;
        for (int i = 0; i < 256; i++) begin
            do_round("b2b", i % 3, 0);
        end
        n_cmp++;
        if (rounds !== 8'd0) begin
            n_bad++;
            $display("FAIL b2b_wrap: rounds=%0d, required 0", rounds);
        end
        n_cmp++;
        if (overlap !== 0) begin
            n_bad++;
            $display("FAIL b2b_overlap: %0d overlapping cycles, required 0", overlap);
        end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        delay_ms = 10'd0;
        set_col(C_DARK);
        model_rounds = 8'd0;
        test_reset();
        test_round();
        test_reset_mid();
        test_early();
        test_late();
        test_enter_cap();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
